// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues sequential or redirected reads to a
// synchronous-read instruction memory and buffers responses in a 2-entry FIFO.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr
);

    // Decode handshake: an instruction transfers in a cycle where if_valid and
    // if_ready are both 1 and no redirect is present; while if_valid=1 and the
    // transfer does not happen, if_valid/if_pc/if_instr hold their values.

    logic [31:0] pc_q;
    logic        req_q;
    logic [31:0] req_pc_q;

    logic [31:0] fifo_pc    [2];
    logic [31:0] fifo_instr [2];
    logic [1:0]  count;
    logic        rd_ptr;
    logic        wr_ptr;

    logic        pop;
    logic        push;
    logic        issue;
    logic [2:0]  occupancy;
    logic [31:0] fetch_addr;

    always_comb begin
        if_valid = (count != 2'd0);
        if_pc    = fifo_pc[rd_ptr];
        if_instr = fifo_instr[rd_ptr];
        pop      = if_valid & if_ready & ~redirect_valid;
        push     = req_q & ~redirect_valid;
    end

    // Buffered entries plus the in-flight read, less what leaves this cycle,
    // must stay below the depth so that a new read always has a slot.
    always_comb begin
        occupancy  = {1'b0, count} + {2'b00, req_q} - {2'b00, pop};
        issue      = rst_n & (redirect_valid | (occupancy < 3'(FIFO_DEPTH)));
        fetch_addr = redirect_valid ? {redirect_pc[31:2], 2'b00} : pc_q;
        imem_en    = issue;
        imem_addr  = fetch_addr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= {RESET_PC[31:2], 2'b00};
            req_q    <= 1'b0;
            req_pc_q <= 32'h0000_0000;
        end else begin
            req_q <= issue;
            if (issue) begin
                pc_q     <= fetch_addr + 32'd4;
                req_pc_q <= fetch_addr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count         <= 2'd0;
            rd_ptr        <= 1'b0;
            wr_ptr        <= 1'b0;
            fifo_pc[0]    <= 32'h0000_0000;
            fifo_pc[1]    <= 32'h0000_0000;
            fifo_instr[0] <= 32'h0000_0000;
            fifo_instr[1] <= 32'h0000_0000;
        end else if (redirect_valid) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            if (push) begin
                fifo_pc[wr_ptr]    <= req_pc_q;
                fifo_instr[wr_ptr] <= imem_rdata;
                wr_ptr             <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: synchronous memory model, delivery scoreboard
// against expected pc queue, and explicit checks at reset/stall/redirect points.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;

    int n_vec;
    int n_err;
    logic [31:0] exp_q[$];

    fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_en        (imem_en),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_instr       (if_instr)
    );

    // clock and memory model
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h0000_1000 + {2'b00, a[31:2]};
    endfunction

    initial imem_rdata = 32'h0;
    always @(posedge clk) begin
        if (imem_en) imem_rdata <= mem_word(imem_addr);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // driver and checking tasks
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic rdy, input logic rv, input logic [31:0] rpc);
        logic [31:0] e;
        if_ready       = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #1;
        if (if_valid && rdy && !rv) begin
            n_vec++;
            assert (exp_q.size() != 0) else begin
                n_err++;
                $error("FAIL sb_extra: observed pc %h expected no delivery", if_pc);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("sb_pc", if_pc, e);
                check("sb_instr", if_instr, mem_word(e));
            end
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic stream(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, 1'b0, 32'h0);
            check("stream_valid", {31'b0, if_valid}, 32'd1);
            next();
        end
        check("sb_left", exp_q.size(), 32'd0);
    endtask

    initial begin
        n_vec          = 0;
        n_err          = 0;
        rst_n          = 1'b0;
        if_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_if_valid", {31'b0, if_valid}, 32'd0);
        check("rst_imem_en", {31'b0, imem_en}, 32'd0);
        check("rst_if_pc", if_pc, 32'h0);
        check("rst_if_instr", if_instr, 32'h0);
        rst_n = 1'b1;

        // sequential fetch from RESET_PC, 2-cycle latency
        exp_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
        drive(1'b1, 1'b0, 32'h0);
        check("c0_imem_en", {31'b0, imem_en}, 32'd1);
        check("c0_imem_addr", imem_addr, 32'h0);
        check("c0_if_valid", {31'b0, if_valid}, 32'd0);
        next();
        drive(1'b1, 1'b0, 32'h0);
        check("c1_if_valid", {31'b0, if_valid}, 32'd0);
        check("c1_imem_addr", imem_addr, 32'h4);
        next();
        drive(1'b1, 1'b0, 32'h0);
        check("c2_if_valid", {31'b0, if_valid}, 32'd1);
        next();

        // decode stall for 5 cycles: FIFO fills, fetch stops, outputs hold
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 32'h0);
            check("stall_if_valid", {31'b0, if_valid}, 32'd1);
            check("stall_if_pc", if_pc, 32'h4);
            check("stall_if_instr", if_instr, 32'h1001);
            check("stall_imem_en", {31'b0, imem_en}, 32'd0);
            next();
        end
        stream(4);

        // redirect to 0x43 while the FIFO is full
        drive(1'b0, 1'b0, 32'h0);
        next();
        drive(1'b0, 1'b1, 32'h43);
        check("rd1_imem_en", {31'b0, imem_en}, 32'd1);
        check("rd1_imem_addr", imem_addr, 32'h40);
        check("rd1_head_pc", if_pc, 32'h14);
        next();
        exp_q = '{32'h40, 32'h44};
        drive(1'b1, 1'b0, 32'h0);
        check("rd1_after_valid", {31'b0, if_valid}, 32'd0);
        next();
        stream(2);

        // redirect while the head is valid and accepted: head is flushed
        drive(1'b1, 1'b1, 32'h100);
        check("rd2_head_pc", if_pc, 32'h48);
        check("rd2_imem_addr", imem_addr, 32'h100);
        next();
        exp_q = '{32'h100};
        drive(1'b1, 1'b0, 32'h0);
        check("rd2_after_valid", {31'b0, if_valid}, 32'd0);
        next();
        stream(1);

        // back-to-back redirects, last one wraps across 2^32
        drive(1'b1, 1'b1, 32'h200);
        check("rd3_imem_addr", imem_addr, 32'h200);
        next();
        drive(1'b1, 1'b1, 32'hFFFF_FFF8);
        check("rd4_imem_addr", imem_addr, 32'hFFFF_FFF8);
        next();
        exp_q = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4};
        drive(1'b1, 1'b0, 32'h0);
        check("rd4_after_valid", {31'b0, if_valid}, 32'd0);
        next();
        stream(4);

        // asynchronous reset mid-cycle with one buffered entry
        if_ready = 1'b0;
        #1;
        check("mr_pre_valid", {31'b0, if_valid}, 32'd1);
        check("mr_pre_pc", if_pc, 32'h8);
        #2;
        rst_n = 1'b0;
        #1;
        check("mr_if_valid", {31'b0, if_valid}, 32'd0);
        check("mr_imem_en", {31'b0, imem_en}, 32'd0);
        check("mr_if_pc", if_pc, 32'h0);
        if_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q = '{32'h0, 32'h4, 32'h8};
        drive(1'b1, 1'b0, 32'h0);
        check("mr_c0_imem_en", {31'b0, imem_en}, 32'd1);
        check("mr_c0_imem_addr", imem_addr, 32'h0);
        next();
        drive(1'b1, 1'b0, 32'h0);
        check("mr_c1_if_valid", {31'b0, if_valid}, 32'd0);
        next();
        stream(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
